// File: rtl/aes_spi_frontend_pkg.sv
// Shared AES frontend definitions: default sizes and FIPS-197 reference vectors.
package aes_spi_frontend_pkg;

  localparam int unsigned BLOCK_W_DEF = 128;
  localparam int unsigned CNT_W_DEF   = 8;

  // FIPS-197 Appendix C.1 (AES-128) plaintext, key and ciphertext
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

endpackage

// File: rtl/aes_spi_channel.sv
// One serial operand channel: shift register, saturating bit counter,
// frame-end detection and valid/pending commit of the received block.
module aes_spi_channel
  import aes_spi_frontend_pkg::*;
#(
  parameter int unsigned BLOCK_W = BLOCK_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_cs,
  input  logic               i_conflict,
  input  logic               i_mosi,
  input  logic               i_start,
  input  logic               i_ack,
  output logic               o_miso,
  output logic [BLOCK_W-1:0] o_block,
  output logic               o_valid
);

  logic [BLOCK_W-1:0] r_sr;
  logic [BLOCK_W-1:0] r_out;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_cs_low;
  logic               r_spoil;
  logic               r_valid;
  logic               r_pend;

  logic w_shift;
  logic w_frame_end;
  logic w_good;
  logic w_abort;
  logic w_commit;

  // Frame classification and commit decision for the current cycle
  always_comb begin
    w_shift     = !i_cs && !i_conflict;
    w_frame_end = r_cs_low && i_cs;
    w_good      = w_frame_end && !r_spoil && (32'(r_cnt) >= 32'(BLOCK_W));
    w_abort     = w_frame_end && !w_good;
    // A good frame coinciding with ack counts as arriving after the ack
    w_commit    = (w_good && (!i_start || i_ack)) || (i_ack && r_pend && !w_abort);
  end

  // Shift, count, and commit state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr     <= '0;
      r_out    <= '0;
      r_cnt    <= '0;
      r_cs_low <= 1'b0;
      r_spoil  <= 1'b0;
      r_valid  <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      r_cs_low <= !i_cs;
      if (w_shift) begin
        r_sr <= {r_sr[BLOCK_W-2:0], i_mosi};
        if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
      end
      // A select conflict poisons any frame in progress until its end
      if (i_conflict) r_spoil <= 1'b1;
      if (w_frame_end) begin
        r_cnt   <= '0;
        r_spoil <= 1'b0;
      end
      if (i_ack) r_valid <= 1'b0;
      if (w_abort) begin
        r_pend <= 1'b0;
      end else if (w_good && i_start && !i_ack) begin
        r_pend <= 1'b1;
      end else if (w_commit) begin
        r_out   <= r_sr;
        r_valid <= 1'b1;
        r_pend  <= 1'b0;
      end
    end
  end

  assign o_miso  = !i_cs && r_sr[BLOCK_W-1];
  assign o_block = r_out;
  assign o_valid = r_valid;

endmodule

// File: rtl/aes_spi_frontend.sv
// SPI-style operand loader for an AES core: data and key channels,
// select-conflict detection and the start/start_ack handshake.
module aes_spi_frontend
  import aes_spi_frontend_pkg::*;
#(
  parameter int unsigned BLOCK_W = BLOCK_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cs1,
  input  logic               cs2,
  input  logic               mosi,
  output logic               misod,
  output logic               misok,
  output logic [BLOCK_W-1:0] data_out,
  output logic [BLOCK_W-1:0] key_out,
  output logic               start,
  input  logic               start_ack,
  output logic               err
);

  logic r_start;
  logic r_err;
  logic w_conflict;
  logic w_ack;
  logic w_valid_d;
  logic w_valid_k;

  assign w_conflict = !cs1 && !cs2;
  assign w_ack      = start_ack && r_start;

  // Start request and sticky conflict error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_ack) r_start <= 1'b0;
      else if (w_valid_d && w_valid_k) r_start <= 1'b1;
      if (w_conflict) r_err <= 1'b1;
    end
  end

  aes_spi_channel #(.BLOCK_W(BLOCK_W), .CNT_W(CNT_W)) u_data (
    .clk(clk), .rst(rst), .i_cs(cs1), .i_conflict(w_conflict), .i_mosi(mosi),
    .i_start(r_start), .i_ack(w_ack), .o_miso(misod), .o_block(data_out),
    .o_valid(w_valid_d)
  );

  aes_spi_channel #(.BLOCK_W(BLOCK_W), .CNT_W(CNT_W)) u_key (
    .clk(clk), .rst(rst), .i_cs(cs2), .i_conflict(w_conflict), .i_mosi(mosi),
    .i_start(r_start), .i_ack(w_ack), .o_miso(misok), .o_block(key_out),
    .o_valid(w_valid_k)
  );

  assign start = r_start;
  assign err   = r_err;

endmodule

// File: tb/tb_aes_spi_frontend.sv
// Self-checking bench for aes_spi_frontend: frame table, directed corner
// sequences and randomized frames against a bit-queue reference model.
module tb_aes_spi_frontend;
  import aes_spi_frontend_pkg::*;

  localparam int W = 128;
  localparam logic [W-1:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic clk, rst, cs1, cs2, mosi, start_ack;
  logic misod, misok, start, err;
  logic [W-1:0] data_out, key_out;

  int vectors = 0;
  int miscompares = 0;
  logic last_misod;

  aes_spi_frontend #(.BLOCK_W(W), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cs1(cs1), .cs2(cs2), .mosi(mosi),
    .misod(misod), .misok(misok), .data_out(data_out), .key_out(key_out),
    .start(start), .start_ack(start_ack), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Each channel remembers the last W bits it received (oldest first).
  bit qd[$];
  bit qk[$];
  logic [W-1:0] m_out[2];
  bit m_valid[2], m_pend[2], m_spoil[2], m_prev_low[2];
  int m_cnt[2];
  bit m_start, m_err;

  function automatic logic [W-1:0] opnd(input int ch);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W; i++) v[W-1-i] = (ch == 0) ? qd[i] : qk[i];
    return v;
  endfunction

  task automatic mreset();
    qd.delete();
    qk.delete();
    for (int i = 0; i < W; i++) begin
      qd.push_back(1'b0);
      qk.push_back(1'b0);
    end
    for (int c = 0; c < 2; c++) begin
      m_out[c] = '0; m_valid[c] = 0; m_pend[c] = 0;
      m_spoil[c] = 0; m_prev_low[c] = 0; m_cnt[c] = 0;
    end
    m_start = 0;
    m_err = 0;
  endtask

  task automatic ch_step(input int ch, input bit cs, input bit conflict,
                         input bit ack, input bit st_old, input bit b);
    bit fe, good, abort;
    fe    = m_prev_low[ch] && cs;
    good  = fe && (m_cnt[ch] >= W) && !m_spoil[ch];
    abort = fe && !good;
    if (!cs && !conflict) begin
      if (ch == 0) begin qd.push_back(b); void'(qd.pop_front()); end
      else begin qk.push_back(b); void'(qk.pop_front()); end
      m_cnt[ch]++;
    end
    if (conflict) m_spoil[ch] = 1;
    if (fe) begin m_cnt[ch] = 0; m_spoil[ch] = 0; end
    if (ack) m_valid[ch] = 0;
    if (abort) m_pend[ch] = 0;
    else if (good && st_old && !ack) m_pend[ch] = 1;
    else if (good || (ack && m_pend[ch])) begin
      m_out[ch] = opnd(ch);
      m_valid[ch] = 1;
      m_pend[ch] = 0;
    end
    m_prev_low[ch] = !cs;
  endtask

  task automatic mstep(input bit c1, input bit c2, input bit b, input bit a);
    bit conflict, ack, both_valid, st_old;
    conflict   = !c1 && !c2;
    st_old     = m_start;
    ack        = a && st_old;
    both_valid = m_valid[0] && m_valid[1];
    ch_step(0, c1, conflict, ack, st_old, b);
    ch_step(1, c2, conflict, ack, st_old, b);
    if (ack) m_start = 0;
    else if (both_valid) m_start = 1;
    if (conflict) m_err = 1;
  endtask

  // ---------------- checking / driving ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic tick(input bit c1, input bit c2, input bit b, input bit a);
    cs1 = c1; cs2 = c2; mosi = b; start_ack = a;
    #1;
    last_misod = misod;
    chk("misod", W'(misod), W'(!c1 ? qd[0] : 1'b0));
    chk("misok", W'(misok), W'(!c2 ? qk[0] : 1'b0));
    @(posedge clk);
    mstep(c1, c2, b, a);
    @(negedge clk);
    chk("data_out", data_out, m_out[0]);
    chk("key_out", key_out, m_out[1]);
    chk("start", W'(start), W'(m_start));
    chk("err", W'(err), W'(m_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  // Sends the low nbits of val MSB first (zeros beyond W); random mode adds
  // stray acks and rare select conflicts.
  task automatic send_bits(input int ch, input int nbits, input logic [W-1:0] val, input bit rnd);
    logic [W-1:0] v;
    bit b, a;
    v = val;
    for (int i = 0; i < nbits; i++) begin
      b = (nbits - 1 - i < W) ? v[nbits-1-i] : 1'b0;
      a = rnd && ($urandom_range(0, 7) == 0);
      if (rnd && $urandom_range(0, 299) == 0) tick(1'b0, 1'b0, b, a);
      else if (ch == 0) tick(1'b0, 1'b1, b, a);
      else tick(1'b1, 1'b0, b, a);
    end
  endtask

  task automatic send_frame(input int ch, input int nbits, input logic [W-1:0] val,
                            input bit ack_end, input bit rnd);
    send_bits(ch, nbits, val, rnd);
    tick(1'b1, 1'b1, 1'b0, ack_end);
  endtask

  task automatic do_reset();
    rst = 1'b1; cs1 = 1'b1; cs2 = 1'b1; mosi = 1'b0; start_ack = 1'b0;
    #1;
    chk("rst_data_out", data_out, '0);
    chk("rst_key_out", key_out, '0);
    chk("rst_start", W'(start), '0);
    chk("rst_err", W'(err), '0);
    chk("rst_misod", W'(misod), '0);
    chk("rst_misok", W'(misok), '0);
    mreset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    int kind;          // 0 = frame, 1 = ack pulse
    int ch;
    int nbits;
    logic [W-1:0] val;
    logic [W-1:0] exp_d;
    logic [W-1:0] exp_k;
    bit exp_start;
  } row_t;

  row_t tbl[6];

  initial begin
    tbl[0] = '{0, 0, 128, FIPS_PT,  FIPS_PT, '0,       1'b0};
    tbl[1] = '{0, 1, 128, FIPS_KEY, FIPS_PT, FIPS_KEY, 1'b1};
    tbl[2] = '{1, 0, 0,   '0,       FIPS_PT, FIPS_KEY, 1'b0};
    tbl[3] = '{0, 0, 100, FIPS_CT,  FIPS_PT, FIPS_KEY, 1'b0};
    tbl[4] = '{0, 0, 128, FIPS_CT,  FIPS_CT, FIPS_KEY, 1'b0};
    tbl[5] = '{0, 1, 128, KEY2,     FIPS_CT, KEY2,     1'b1};

    do_reset();

    // Table of frame-level operations
    for (int r = 0; r < 6; r++) begin
      if (tbl[r].kind == 0) send_frame(tbl[r].ch, tbl[r].nbits, tbl[r].val, 1'b0, 1'b0);
      else tick(1'b1, 1'b1, 1'b0, 1'b1);
      idle(2);
      chk($sformatf("tbl%0d_data", r), data_out, tbl[r].exp_d);
      chk($sformatf("tbl%0d_key", r), key_out, tbl[r].exp_k);
      chk($sformatf("tbl%0d_start", r), W'(start), W'(tbl[r].exp_start));
    end

    // Echo: data register holds CT, new block pushes it out MSB first
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    begin
      logic [W-1:0] ct, pt;
      ct = FIPS_CT;
      pt = FIPS_PT;
      for (int i = 0; i < W; i++) begin
        tick(1'b0, 1'b1, pt[W-1-i], 1'b0);
        chk("echo_misod", W'(last_misod), W'(ct[W-1-i]));
      end
    end
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("echo_data", data_out, FIPS_PT);
    chk("echo_start", W'(start), '0);

    // Key resend while start high stays frozen until ack
    send_frame(1, 128, KEY2, 1'b0, 1'b0);
    idle(2);
    chk("pend_start_hi", W'(start), W'(1));
    send_frame(1, 128, FIPS_KEY, 1'b0, 1'b0);
    idle(2);
    chk("pend_key_frozen", key_out, KEY2);
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    chk("pend_key_commit", key_out, FIPS_KEY);
    chk("pend_start_lo", W'(start), '0);
    idle(3);
    chk("pend_start_stays_lo", W'(start), '0);

    // Frame end coinciding with ack
    send_frame(0, 128, FIPS_CT, 1'b0, 1'b0);
    idle(2);
    chk("coinc_start_hi", W'(start), W'(1));
    send_frame(0, 128, FIPS_PT, 1'b1, 1'b0);
    chk("coinc_data", data_out, FIPS_PT);
    chk("coinc_start", W'(start), '0);
    idle(3);
    chk("coinc_start_stays_lo", W'(start), '0);

    // Select conflict mid-frame
    send_bits(0, 50, FIPS_CT, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    chk("conf_err", W'(err), W'(1));
    chk("conf_data", data_out, FIPS_PT);
    idle(5);
    chk("conf_err_held", W'(err), W'(1));

    // Reset at bit 64 of a data frame
    send_bits(0, 64, FIPS_CT, 1'b0);
    do_reset();
    send_frame(0, 128, FIPS_CT, 1'b0, 1'b0);
    idle(1);
    chk("post_rst_data", data_out, FIPS_CT);
    chk("post_rst_key", key_out, '0);
    chk("post_rst_err", W'(err), '0);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      int ch, len, sel;
      logic [W-1:0] v;
      ch  = $urandom_range(0, 1);
      sel = $urandom_range(0, 7);
      if (sel < 2) len = $urandom_range(1, 127);
      else if (sel == 7) len = $urandom_range(256, 300);
      else len = 128 + $urandom_range(0, 3);
      v = {$urandom, $urandom, $urandom, $urandom};
      send_frame(ch, len, v, ($urandom_range(0, 3) == 0), 1'b1);
      for (int g = 0; g < $urandom_range(0, 3); g++)
        tick(1'b1, 1'b1, 1'b0, ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
